foc_loop_scheduler: RTL

- Periodic control-loop scheduler for the FOC datapath.
- Every control period it triggers an encoder read, then one current-loop/modulation pass, and every SPD_DIV-th period it issues a speed-loop strobe.
- Supervises both stages with timeouts, encoder-warning accounting, PLL-lock loss and period overrun; latches a fault code and holds the datapath idle until it is cleared.
- Sits at top level between the PLL lock output, the encoder data-treatment block and the current-loop block.

---
 rtl/foc_loop_scheduler_if.sv | 36 +++
 rtl/foc_loop_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/foc_loop_scheduler_if.sv
// Signal bundle between the FOC loop scheduler and the blocks it sequences
// (PLL lock, encoder data treatment, current loop).
// Handshake rule: every start/done/strobe line is a single-cycle pulse, sampled on
// the rising clock edge. A start pulse (oCdt_en, oCl_en) is answered by exactly
// one done pulse (iCdt_done, iModulate_done). There is no back-pressure: the
// scheduler owns the timing and enforces timeouts on the answering side.
interface foc_loop_scheduler_if;
  logic       iPll_locked;
  logic       iEnable;
  logic       iCdt_done;
  logic       iCdt_warning;
  logic       iModulate_done;
  logic       iFault_clr;
  logic       oCdt_en;
  logic       oCl_en;
  logic       oSpd_en;
  logic       oPeriod_tick;
  logic       oRunning;
  logic       oFault;
  logic [2:0] oFault_code;
  logic [7:0] oOverrun_cnt;

  // Scheduler side
  modport master (
    input  iPll_locked, iEnable, iCdt_done, iCdt_warning, iModulate_done, iFault_clr,
    output oCdt_en, oCl_en, oSpd_en, oPeriod_tick, oRunning, oFault, oFault_code,
           oOverrun_cnt
  );

  // Environment side (PLL, encoder block, current loop, supervisor)
  modport slave (
    output iPll_locked, iEnable, iCdt_done, iCdt_warning, iModulate_done, iFault_clr,
    input  oCdt_en, oCl_en, oSpd_en, oPeriod_tick, oRunning, oFault, oFault_code,
           oOverrun_cnt
  );
endinterface

// File: rtl/foc_loop_scheduler.sv
// Periodic FOC control-loop scheduler. Each control period starts an encoder
// read, then one current-loop/modulation pass; every SPD_DIV-th pass also
// strobes the speed loop. Stage timeouts, encoder-warning runs, PLL loss and
// period overruns are supervised; a fault is latched until explicitly cleared.
module foc_loop_scheduler #(
  parameter int PERIOD_CYC  = 5000,
  parameter int SPD_DIV     = 10,
  parameter int CDT_TIMEOUT = 2000,
  parameter int CL_TIMEOUT  = 4000,
  parameter int WARN_LIMIT  = 3
) (
  input  logic                  nclk_100m,
  input  logic                  iRst_n,
  foc_loop_scheduler_if.master  bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_CDT       = 3'd2,
    S_CL        = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int PER_W  = $clog2(PERIOD_CYC);
  localparam int TO_MAX = (CL_TIMEOUT > CDT_TIMEOUT) ? CL_TIMEOUT : CDT_TIMEOUT;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam int SPD_W  = $clog2(SPD_DIV + 1);
  localparam int WARN_W = $clog2(WARN_LIMIT + 1);

  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]   CDT_LOAD = TO_W'(CDT_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   CL_LOAD  = TO_W'(CL_TIMEOUT - 1);
  localparam logic [SPD_W-1:0]  SPD_LAST = SPD_W'(SPD_DIV - 1);
  localparam logic [WARN_W-1:0] WARN_MAX = WARN_W'(WARN_LIMIT);

  localparam logic [2:0] FC_CDT_TO = 3'd1;
  localparam logic [2:0] FC_CL_TO  = 3'd2;
  localparam logic [2:0] FC_WARN   = 3'd3;
  localparam logic [2:0] FC_PLL    = 3'd4;

  state_t             r_state;
  logic [PER_W-1:0]   r_per_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [SPD_W-1:0]   r_spd_idx;
  logic [WARN_W-1:0]  r_warn_cnt;
  logic               r_pending;
  logic               r_cdt_en;
  logic               r_cl_en;
  logic               r_spd_en;
  logic               r_tick;
  logic               r_running;
  logic               r_fault;
  logic [2:0]         r_fault_code;
  logic [7:0]         r_ovr_cnt;

  logic               w_active;
  logic               w_tick;
  logic               w_to_zero;
  logic [WARN_W-1:0]  w_warn_inc;
  logic               w_warn_hit;
  logic               w_spd_wrap;
  logic               w_ovr_hit;

  // The period counter only advances while the loop is live.
  assign w_active   = (r_state == S_WAIT_TICK) || (r_state == S_CDT) || (r_state == S_CL);
  assign w_tick     = w_active && (r_per_cnt == PER_LAST);
  assign w_to_zero  = (r_to_cnt == '0);
  assign w_warn_inc = r_warn_cnt + WARN_W'(1);
  assign w_warn_hit = bus.iCdt_warning && (w_warn_inc == WARN_MAX);
  assign w_spd_wrap = (r_spd_idx == SPD_LAST);
  // A tick landing on the same cycle as modulate_done is deferred, not lost.
  assign w_ovr_hit  = w_tick && ((r_state == S_CDT) ||
                                 ((r_state == S_CL) && !bus.iModulate_done));

  assign bus.oCdt_en      = r_cdt_en;
  assign bus.oCl_en       = r_cl_en;
  assign bus.oSpd_en      = r_spd_en;
  assign bus.oPeriod_tick = r_tick;
  assign bus.oRunning     = r_running;
  assign bus.oFault       = r_fault;
  assign bus.oFault_code  = r_fault_code;
  assign bus.oOverrun_cnt = r_ovr_cnt;
  assign o_dbg_state      = r_state;

  // Free-running period counter: cleared in IDLE, frozen in FAULT, wraps on tick.
  always_ff @(posedge nclk_100m or negedge iRst_n) begin
    if (!iRst_n) begin
      r_per_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (r_state == S_IDLE) begin
        r_per_cnt <= '0;
      end else if (w_active) begin
        if (w_tick) r_per_cnt <= '0;
        else        r_per_cnt <= r_per_cnt + PER_W'(1);
      end
    end
  end

  // Scheduler FSM with registered pulse, status and fault outputs.
  always_ff @(posedge nclk_100m or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state      <= S_IDLE;
      r_to_cnt     <= '0;
      r_spd_idx    <= '0;
      r_warn_cnt   <= '0;
      r_pending    <= 1'b0;
      r_cdt_en     <= 1'b0;
      r_cl_en      <= 1'b0;
      r_spd_en     <= 1'b0;
      r_running    <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
      r_ovr_cnt    <= 8'd0;
    end else begin
      r_cdt_en <= 1'b0;
      r_cl_en  <= 1'b0;
      r_spd_en <= 1'b0;
      if (w_ovr_hit && (r_ovr_cnt != 8'hFF)) r_ovr_cnt <= r_ovr_cnt + 8'd1;

      case (r_state)
        S_IDLE: begin
          r_spd_idx  <= '0;
          r_warn_cnt <= '0;
          r_pending  <= 1'b0;
          if (bus.iEnable && bus.iPll_locked) begin
            r_state   <= S_WAIT_TICK;
            r_running <= 1'b1;
          end
        end

        S_WAIT_TICK: begin
          if (!bus.iPll_locked) begin
            r_state      <= S_FAULT;
            r_running    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_PLL;
          end else if (!bus.iEnable) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_pending <= 1'b0;
          end else if (w_tick || r_pending) begin
            r_pending <= 1'b0;
            r_cdt_en  <= 1'b1;
            r_to_cnt  <= CDT_LOAD;
            r_state   <= S_CDT;
          end
        end

        S_CDT: begin
          if (!bus.iPll_locked) begin
            r_state      <= S_FAULT;
            r_running    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_PLL;
          end else if (bus.iCdt_done) begin
            r_warn_cnt <= bus.iCdt_warning ? w_warn_inc : '0;
            if (w_warn_hit) begin
              r_state      <= S_FAULT;
              r_running    <= 1'b0;
              r_fault      <= 1'b1;
              r_fault_code <= FC_WARN;
            end else begin
              r_cl_en  <= 1'b1;
              r_to_cnt <= CL_LOAD;
              r_state  <= S_CL;
            end
          end else if (w_to_zero) begin
            r_state      <= S_FAULT;
            r_running    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_CDT_TO;
          end else begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end

        S_CL: begin
          if (!bus.iPll_locked) begin
            r_state      <= S_FAULT;
            r_running    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_PLL;
          end else if (bus.iModulate_done) begin
            if (w_spd_wrap) begin
              r_spd_idx <= '0;
              r_spd_en  <= 1'b1;
            end else begin
              r_spd_idx <= r_spd_idx + SPD_W'(1);
            end
            if (!bus.iEnable) begin
              r_state   <= S_IDLE;
              r_running <= 1'b0;
              r_pending <= 1'b0;
            end else begin
              r_state   <= S_WAIT_TICK;
              r_pending <= w_tick;
            end
          end else if (w_to_zero) begin
            r_state      <= S_FAULT;
            r_running    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_CL_TO;
          end else begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end

        S_FAULT: begin
          if (bus.iFault_clr && !bus.iEnable && bus.iPll_locked) begin
            r_state      <= S_IDLE;
            r_fault      <= 1'b0;
            r_fault_code <= 3'd0;
            r_ovr_cnt    <= 8'd0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

endmodule
